// File: rtl/vector_element_counter_if.sv
// Bundles the per-channel control inputs and beat outputs of vector_element_counter.
// The stall_cycles bus exists only when ELEMENT_COUNTER_PERF_EN is defined.
interface vector_element_counter_if #(
    parameter int NUM_COUNTERS = 2,
    parameter int VL_W         = 8,
    parameter int LANES        = 4,
    parameter int EPC_W        = $clog2(LANES) + 1
);
    logic [NUM_COUNTERS*VL_W-1:0]  vstart;
    logic [NUM_COUNTERS*VL_W-1:0]  vl;
    logic [NUM_COUNTERS*EPC_W-1:0] epc;
    logic [NUM_COUNTERS-1:0]       start;
    logic [NUM_COUNTERS-1:0]       stall;
    logic [NUM_COUNTERS-1:0]       ex_return;
    logic [NUM_COUNTERS-1:0]       clear;
    logic [NUM_COUNTERS-1:0]       busy;
    logic [NUM_COUNTERS*VL_W-1:0]  offset;
    logic [NUM_COUNTERS*LANES-1:0] lane_valid;
    logic [NUM_COUNTERS-1:0]       next_done;
    logic [NUM_COUNTERS-1:0]       done;
`ifdef ELEMENT_COUNTER_PERF_EN
    logic [NUM_COUNTERS*32-1:0]    stall_cycles;
`endif

    modport master (
`ifdef ELEMENT_COUNTER_PERF_EN
        input  stall_cycles,
`endif
        output vstart, vl, epc, start, stall, ex_return, clear,
        input  busy, offset, lane_valid, next_done, done
    );

    modport slave (
`ifdef ELEMENT_COUNTER_PERF_EN
        output stall_cycles,
`endif
        input  vstart, vl, epc, start, stall, ex_return, clear,
        output busy, offset, lane_valid, next_done, done
    );
endinterface

// File: rtl/vector_element_counter.sv
// Multi-channel element sequencer: walks vstart..vl-1 at up to LANES elements per beat.
// Optional ELEMENT_COUNTER_PERF_EN adds a saturating per-channel stall-cycle counter.
module vector_element_counter #(
    parameter int NUM_COUNTERS = 2,
    parameter int VL_W         = 8,
    parameter int LANES        = 4,
    parameter int EPC_W        = $clog2(LANES) + 1
) (
    input logic                      CLK,
    input logic                      RST,
    vector_element_counter_if.slave  ctr_if
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    function automatic logic [EPC_W-1:0] clamp_epc(input logic [EPC_W-1:0] e);
        logic [EPC_W-1:0] r;
        if (e == {EPC_W{1'b0}}) begin
            r = EPC_W'(1);
        end else if (e > EPC_W'(LANES)) begin
            r = EPC_W'(LANES);
        end else begin
            r = e;
        end
        return r;
    endfunction

    logic [NUM_COUNTERS-1:0]       busy_s, next_done_s, done_s;
    logic [NUM_COUNTERS*VL_W-1:0]  offset_s;
    logic [NUM_COUNTERS*LANES-1:0] lane_s;
`ifdef ELEMENT_COUNTER_PERF_EN
    logic [NUM_COUNTERS*32-1:0]    stall_cycles_s;
`endif

    for (genvar c = 0; c < NUM_COUNTERS; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [VL_W-1:0]  offset_q, offset_d, vl_q, vl_d;
        logic [EPC_W-1:0] epc_q, epc_d;
        logic [VL_W:0]    sum_s;
        logic             run_s, last_s;
        logic             start_s, stall_s, ex_s, clr_s;

        assign start_s = ctr_if.start[c];
        assign stall_s = ctr_if.stall[c];
        assign ex_s    = ctr_if.ex_return[c];
        assign clr_s   = ctr_if.clear[c];

        // One extra bit so offset+epc never wraps near 2^VL_W-1
        assign sum_s  = {1'b0, offset_q} + (VL_W+1)'(epc_q);
        assign run_s  = (state_q == RUN);
        assign last_s = (sum_s >= {1'b0, vl_q});

        // Next-state: clear beats ex_return beats start beats advance
        always_comb begin
            state_d  = state_q;
            offset_d = offset_q;
            vl_d     = vl_q;
            epc_d    = epc_q;
            if (clr_s) begin
                state_d  = IDLE;
                offset_d = {VL_W{1'b0}};
            end else if (ex_s) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_s) begin
                            state_d  = RUN;
                            offset_d = ctr_if.vstart[c*VL_W +: VL_W];
                            vl_d     = ctr_if.vl[c*VL_W +: VL_W];
                            epc_d    = clamp_epc(ctr_if.epc[c*EPC_W +: EPC_W]);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    RUN: begin
                        if (stall_s) begin
                            state_d = RUN;
                        end else if (last_s) begin
                            state_d = IDLE;
                        end else begin
                            offset_d = sum_s[VL_W-1:0];
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Channel state registers
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q  <= IDLE;
                offset_q <= {VL_W{1'b0}};
                vl_q     <= {VL_W{1'b0}};
                epc_q    <= EPC_W'(1);
            end else begin
                state_q  <= state_d;
                offset_q <= offset_d;
                vl_q     <= vl_d;
                epc_q    <= epc_d;
            end
        end

        assign busy_s[c]                   = run_s;
        assign offset_s[c*VL_W +: VL_W]    = offset_q;
        assign next_done_s[c]              = run_s && last_s;
        // An aborted final beat does not retire
        assign done_s[c]                   = run_s && last_s && !stall_s && !clr_s && !ex_s;

        for (genvar j = 0; j < LANES; j++) begin : g_lane
            assign lane_s[c*LANES+j] = run_s && (epc_q > EPC_W'(j)) &&
                                       (({1'b0, offset_q} + (VL_W+1)'(j)) < {1'b0, vl_q});
        end

`ifdef ELEMENT_COUNTER_PERF_EN
        logic [31:0] stc_q, stc_d;

        // Stall-cycle counter: zeroed by clear or an accepted start, saturates
        always_comb begin
            stc_d = stc_q;
            if (clr_s) begin
                stc_d = 32'd0;
            end else if (!run_s && start_s && !ex_s) begin
                stc_d = 32'd0;
            end else if (run_s && stall_s && (stc_q != 32'hFFFF_FFFF)) begin
                stc_d = stc_q + 32'd1;
            end else begin
                stc_d = stc_q;
            end
        end

        // Stall-cycle counter register
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                stc_q <= 32'd0;
            end else begin
                stc_q <= stc_d;
            end
        end

        assign stall_cycles_s[c*32 +: 32] = stc_q;
`endif
    end

    assign ctr_if.busy       = busy_s;
    assign ctr_if.offset     = offset_s;
    assign ctr_if.lane_valid = lane_s;
    assign ctr_if.next_done  = next_done_s;
    assign ctr_if.done       = done_s;
`ifdef ELEMENT_COUNTER_PERF_EN
    assign ctr_if.stall_cycles = stall_cycles_s;
`endif
endmodule

// File: tb/tb_vector_element_counter.sv
// Directed bench for vector_element_counter with hand-computed per-beat expectations.
module tb_vector_element_counter;
    localparam int NC = 2;
    localparam int VW = 8;
    localparam int LN = 4;
    localparam int EW = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    vector_element_counter_if #(.NUM_COUNTERS(NC), .VL_W(VW), .LANES(LN), .EPC_W(EW)) bus ();

    vector_element_counter #(.NUM_COUNTERS(NC), .VL_W(VW), .LANES(LN), .EPC_W(EW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ctr_if (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int ch, input logic [7:0] vs, input logic [7:0] v, input logic [2:0] e);
        bus.vstart[ch*VW +: VW] = vs;
        bus.vl[ch*VW +: VW]     = v;
        bus.epc[ch*EW +: EW]    = e;
    endtask

    // One clock: drive controls after the rising edge, return at the falling edge
    task automatic cyc(input logic [1:0] s, input logic [1:0] st, input logic [1:0] ex, input logic [1:0] cl);
        @(posedge CLK);
        #1;
        bus.start = s; bus.stall = st; bus.ex_return = ex; bus.clear = cl;
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input int ch, input logic b, input logic [7:0] off,
                       input logic [3:0] lv, input logic nd, input logic dn);
        check_eq({tag, ".busy"},  64'(bus.busy[ch]), 64'(b));
        check_eq({tag, ".off"},   64'(bus.offset[ch*VW +: VW]), 64'(off));
        check_eq({tag, ".lanes"}, 64'(bus.lane_valid[ch*LN +: LN]), 64'(lv));
        check_eq({tag, ".ndone"}, 64'(bus.next_done[ch]), 64'(nd));
        check_eq({tag, ".done"},  64'(bus.done[ch]), 64'(dn));
    endtask

    initial begin
        bus.start = 2'b00; bus.stall = 2'b00; bus.ex_return = 2'b00; bus.clear = 2'b00;
        bus.vstart = '0; bus.vl = '0; bus.epc = '0;
        #12;
        chk("rst", 0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        chk("rst", 1, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        RST = 1'b0;

        // Basic run: 0..9 by 4
        cfg(0, 8'd0, 8'd10, 3'd4);
        cyc(2'b01, 2'b00, 2'b00, 2'b00); chk("t1.idle", 0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t1.b0",   0, 1'b1, 8'd0, 4'hF, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t1.b1",   0, 1'b1, 8'd4, 4'hF, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t1.b2",   0, 1'b1, 8'd8, 4'h3, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t1.end",  0, 1'b0, 8'd8, 4'h0, 1'b0, 1'b0);

        // Stall held on the final beat
        cfg(0, 8'd2, 8'd5, 3'd2);
        cyc(2'b01, 2'b00, 2'b00, 2'b00); chk("t2.idle", 0, 1'b0, 8'd8, 4'h0, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t2.b0",   0, 1'b1, 8'd2, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 2'b01, 2'b00, 2'b00); chk("t2.stl", 0, 1'b1, 8'd4, 4'h1, 1'b1, 1'b0);
        end
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t2.b1",   0, 1'b1, 8'd4, 4'h1, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t2.end",  0, 1'b0, 8'd4, 4'h0, 1'b0, 1'b0);
`ifdef ELEMENT_COUNTER_PERF_EN
        check_eq("t2.stc", 64'(bus.stall_cycles[31:0]), 64'd3);
`endif

        // Empty vectors: vstart==vl and vl==0
        cfg(0, 8'd6, 8'd6, 3'd1);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t3.eq",   0, 1'b1, 8'd6, 4'h0, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t3.eqe",  0, 1'b0, 8'd6, 4'h0, 1'b0, 1'b0);
        cfg(0, 8'd6, 8'd0, 3'd1);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t3.vl0",  0, 1'b1, 8'd6, 4'h0, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t3.vl0e", 0, 1'b0, 8'd6, 4'h0, 1'b0, 1'b0);

        // Abort paths on vl=20, epc=3
        cfg(0, 8'd0, 8'd20, 3'd3);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.run", 0, 1'b1, 8'(3*k), 4'h7, 1'b0, 1'b0);
        end
        cyc(2'b00, 2'b00, 2'b01, 2'b00); chk("t4.ex",   0, 1'b1, 8'd9, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.exi",  0, 1'b0, 8'd9, 4'h0, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.r0",   0, 1'b1, 8'd0, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.r3",   0, 1'b1, 8'd3, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b01); chk("t4.clr",  0, 1'b1, 8'd6, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.clri", 0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.q0",   0, 1'b1, 8'd0, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b01, 2'b01); chk("t4.both", 0, 1'b1, 8'd3, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t4.bi",   0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);

        // epc clamp and top-of-range boundary
        cfg(0, 8'd0, 8'd3, 3'd0);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.z0", 0, 1'b1, 8'd0, 4'h1, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.z1", 0, 1'b1, 8'd1, 4'h1, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.z2", 0, 1'b1, 8'd2, 4'h1, 1'b1, 1'b1);
        cfg(0, 8'd0, 8'd6, 3'd7);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.s0", 0, 1'b1, 8'd0, 4'hF, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.s1", 0, 1'b1, 8'd4, 4'h3, 1'b1, 1'b1);
        cfg(0, 8'd252, 8'd255, 3'd4);
        cyc(2'b01, 2'b00, 2'b00, 2'b00);
        cyc(2'b01, 2'b00, 2'b00, 2'b00); chk("t5.top",  0, 1'b1, 8'd252, 4'h7, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t5.topi", 0, 1'b0, 8'd252, 4'h0, 1'b0, 1'b0);

        // Two channels concurrently, stalls on channel 1 only
        cfg(0, 8'd0, 8'd8, 3'd2);
        cfg(1, 8'd1, 8'd7, 3'd3);
        cyc(2'b11, 2'b00, 2'b00, 2'b00); chk("t6.i1", 1, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        cyc(2'b00, 2'b10, 2'b00, 2'b00);
        chk("t6.a0", 0, 1'b1, 8'd0, 4'h3, 1'b0, 1'b0); chk("t6.a1", 1, 1'b1, 8'd1, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b10, 2'b00, 2'b00);
        chk("t6.b0", 0, 1'b1, 8'd2, 4'h3, 1'b0, 1'b0); chk("t6.b1", 1, 1'b1, 8'd1, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        chk("t6.c0", 0, 1'b1, 8'd4, 4'h3, 1'b0, 1'b0); chk("t6.c1", 1, 1'b1, 8'd1, 4'h7, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        chk("t6.d0", 0, 1'b1, 8'd6, 4'h3, 1'b1, 1'b1); chk("t6.d1", 1, 1'b1, 8'd4, 4'h7, 1'b1, 1'b1);
        cyc(2'b00, 2'b00, 2'b00, 2'b00);
        chk("t6.e0", 0, 1'b0, 8'd6, 4'h0, 1'b0, 1'b0); chk("t6.e1", 1, 1'b0, 8'd4, 4'h0, 1'b0, 1'b0);
`ifdef ELEMENT_COUNTER_PERF_EN
        check_eq("t6.stc1", 64'(bus.stall_cycles[63:32]), 64'd2);
`endif

        // Asynchronous reset mid-run
        cfg(0, 8'd0, 8'd20, 3'd1);
        cfg(1, 8'd3, 8'd20, 3'd2);
        cyc(2'b11, 2'b00, 2'b00, 2'b00);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t7.r0", 0, 1'b1, 8'd0, 4'h1, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t7.r1", 0, 1'b1, 8'd1, 4'h1, 1'b0, 1'b0);
        chk("t7.q1", 1, 1'b1, 8'd5, 4'h3, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1;
        chk("t7.rst0", 0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        chk("t7.rst1", 1, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 2'b00); chk("t7.post", 0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/vector_element_counter.md
Name: vector_element_counter

Overview:
- Multi-channel element sequencer for the rv32v lanes.
- Each channel walks element indices from vstart to vl-1 at up to LANES elements per cycle.
- Each channel produces the per-lane valid masks, the base offset, and busy/done/next_done to the execute units.
- Next-generation element counter: runtime elements-per-cycle, lane masks and explicit abort/clear priority.

Parameters:
- NUM_COUNTERS, 2, number of independent channels.
- VL_W, 8, width of vstart/vl/offset (max vl = 2^VL_W - 1).
- LANES, 4, maximum elements processed per cycle per channel.
- EPC_W, $clog2(LANES)+1, width of the elements-per-cycle input.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- vstart  input  NUM_COUNTERS*VL_W  per-channel start element index.
- vl  input  NUM_COUNTERS*VL_W  per-channel vector length.
- epc  input  NUM_COUNTERS*EPC_W  per-channel elements per cycle.
- start  input  NUM_COUNTERS  begin a sequence (sampled in IDLE only).
- stall  input  NUM_COUNTERS  hold current beat.
- ex_return  input  NUM_COUNTERS  abort on exception, keep offset.
- clear  input  NUM_COUNTERS  abort and zero offset.
- busy  output  NUM_COUNTERS  channel in RUN.
- offset  output  NUM_COUNTERS*VL_W  element index of lane 0 this beat.
- lane_valid  output  NUM_COUNTERS*LANES  lane j active this beat.
- next_done  output  NUM_COUNTERS  current beat is the final beat.
- done  output  NUM_COUNTERS  final beat retires this cycle (1-cycle pulse).

Behaviour:
- Reset (async, any time, including mid-run): all channels go to IDLE. Registers cleared: offset=0, vl_q=0, epc_q=1. All outputs 0.
- Channel state machine: IDLE, RUN.
- IDLE -> RUN:
  - On start: offset<=vstart, vl_q<=vl, epc_q<=clamp(epc).
  - clamp rule: epc=0 becomes 1; epc>LANES becomes LANES.
  - First beat is visible the cycle after start (1-cycle latency).
- In RUN:
  - busy=1.
  - lane_valid[j] = (j<epc_q) && (offset+j < vl_q).
  - last = (offset+epc_q >= vl_q).
  - next_done = last.
  - done = last && !stall.
- Beat advance in RUN:
  - If !stall and !last: offset<=offset+epc_q.
  - If !stall and last: go to IDLE; offset holds its final value.
  - stall freezes offset and state. Outputs are stable while stalled.
- All compares and additions use VL_W+1 bits. No wrap at 2^VL_W - 1.
- vstart>=vl, including vl=0: enter RUN with every lane_valid bit 0. done pulses on the first unstalled cycle.
- Start handling:
  - start is ignored while in RUN.
  - start in the same cycle as the done pulse is ignored; it must be reissued in IDLE.
- Priority per channel, highest first: clear > ex_return > start > advance.
  - clear (either state): go to IDLE, offset<=0, no done.
  - ex_return (either state): go to IDLE, offset holds (identifies the faulting element for vstart writeback), no done.
- In IDLE: busy, lane_valid, done and next_done are 0; offset shows its last value.
- Channels are fully independent; there are no cross-channel interactions.

Optional Feature:
- Macro: ELEMENT_COUNTER_PERF_EN.
- Defined: adds output stall_cycles, NUM_COUNTERS*32.
  - Per channel, increments on each RUN&&stall cycle.
  - Zeroed by RST, by start accepted in IDLE, and by clear.
  - Saturates at 2^32-1.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic run, LANES=4: vstart=0, vl=10, epc=4, start one cycle, no stalls.
  - Offsets 0, 4, 8 on three beats.
  - lane_valid 1111, 1111, 0011.
  - next_done and done high on the third beat only; busy falls the cycle after.
- Stall on last beat: vstart=2, vl=5, epc=2.
  - Offsets 2, 4; last beat 0001.
  - stall held 3 cycles on offset 4: next_done=1 and done=0 throughout.
  - done pulses once when stall drops.
- Empty vector: vstart=6, vl=6, epc=1 -> one RUN cycle, lane_valid=0000, done=1.
  - Repeat with vl=0: same result.
- Abort paths: vl=20, epc=3.
  - ex_return at offset 9 -> IDLE, offset stays 9, no done.
  - Rerun, then clear at offset 6 -> IDLE, offset=0, no done.
  - Rerun with clear and ex_return asserted together -> offset=0.
- Clamp and boundary, VL_W=8:
  - epc=0 -> steps of 1.
  - epc=7 -> steps of 4.
  - vstart=252, vl=255, epc=4 -> single beat, lane_valid=0111, no offset wrap.
- Independence and reset: channel 0 and channel 1 run different vl/epc concurrently with stalls on channel 1 only; outputs match per-channel models.
  - RST asserted mid-run, asynchronous between clock edges -> all outputs 0 immediately.
